// File: rtl/forwarding_unit_pkg.sv
// Shared constants for the EX-stage operand bypass logic: mux select
// encodings and the architectural register-address width.
package forwarding_unit_pkg;

  localparam int FWD_REG_AW = 5;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b10;
  localparam fwd_sel_t FWD_MEMWB = 2'b01;

endpackage

// File: rtl/forwarding_unit_fwd_select.sv
// Single-operand bypass comparator: picks the youngest in-flight producer of
// rs, never forwarding a write to x0.
module fwd_select
  import forwarding_unit_pkg::*;
#(
  parameter int REG_AW = FWD_REG_AW
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic              exmem_regwr_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              memwb_regwr_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  output logic [1:0]        sel_o
);

  logic exmem_hit_s;
  logic memwb_hit_s;

  assign exmem_hit_s = exmem_regwr_i && (exmem_rd_i != {REG_AW{1'b0}}) && (exmem_rd_i == rs_i);
  assign memwb_hit_s = memwb_regwr_i && (memwb_rd_i != {REG_AW{1'b0}}) && (memwb_rd_i == rs_i);

  // EX/MEM holds the younger result, so it outranks MEM/WB.
  always_comb begin
    sel_o = FWD_RF;
    if (exmem_hit_s) begin
      sel_o = FWD_EXMEM;
    end else if (memwb_hit_s) begin
      sel_o = FWD_MEMWB;
    end else begin
      sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/forwarding_unit.sv
// Operand-forwarding selector for the EX stage with performance counters of
// how many operands were bypassed from each later pipeline stage.
module forwarding_unit
  import forwarding_unit_pkg::*;
#(
  parameter int REG_AW = FWD_REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exmem_regwr,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              memwb_regwr,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [REG_AW-1:0] idex_rs1,
  input  logic [REG_AW-1:0] idex_rs2,
  output logic [1:0]        forwardA,
  output logic [1:0]        forwardB,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  fwd_cnt_exmem,
  output logic [CNT_W-1:0]  fwd_cnt_memwb
);

  logic [1:0]       sel_a_s;
  logic [1:0]       sel_b_s;
  logic [1:0]       n_exmem_s;
  logic [1:0]       n_memwb_s;
  logic [CNT_W-1:0] cnt_exmem_d;
  logic [CNT_W-1:0] cnt_exmem_q;
  logic [CNT_W-1:0] cnt_memwb_d;
  logic [CNT_W-1:0] cnt_memwb_q;

  fwd_select #(.REG_AW(REG_AW)) u_sel_a (
    .rs_i          (idex_rs1),
    .exmem_regwr_i (exmem_regwr),
    .exmem_rd_i    (exmem_rd),
    .memwb_regwr_i (memwb_regwr),
    .memwb_rd_i    (memwb_rd),
    .sel_o         (sel_a_s)
  );

  fwd_select #(.REG_AW(REG_AW)) u_sel_b (
    .rs_i          (idex_rs2),
    .exmem_regwr_i (exmem_regwr),
    .exmem_rd_i    (exmem_rd),
    .memwb_regwr_i (memwb_regwr),
    .memwb_rd_i    (memwb_rd),
    .sel_o         (sel_b_s)
  );

  assign forwardA = sel_a_s;
  assign forwardB = sel_b_s;

  // Each cycle both operands may bypass, so a counter advances by 0, 1 or 2.
  always_comb begin
    n_exmem_s   = {1'b0, (sel_a_s == FWD_EXMEM)} + {1'b0, (sel_b_s == FWD_EXMEM)};
    n_memwb_s   = {1'b0, (sel_a_s == FWD_MEMWB)} + {1'b0, (sel_b_s == FWD_MEMWB)};
    cnt_exmem_d = cnt_exmem_q + CNT_W'(n_exmem_s);
    cnt_memwb_d = cnt_memwb_q + CNT_W'(n_memwb_s);
  end

  // Counter state: async reset, then clear outranks increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_exmem_q <= {CNT_W{1'b0}};
      cnt_memwb_q <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      cnt_exmem_q <= {CNT_W{1'b0}};
      cnt_memwb_q <= {CNT_W{1'b0}};
    end else begin
      cnt_exmem_q <= cnt_exmem_d;
      cnt_memwb_q <= cnt_memwb_d;
    end
  end

  assign fwd_cnt_exmem = cnt_exmem_q;
  assign fwd_cnt_memwb = cnt_memwb_q;

endmodule

// File: tb/tb_forwarding_unit.sv
// Randomised bench for forwarding_unit: a full-width and a 3-bit-counter
// instance are checked every cycle against an arithmetic reference model.
module tb_forwarding_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exmem_regwr = 1'b0;
  logic [4:0]  exmem_rd = 5'd0;
  logic        memwb_regwr = 1'b0;
  logic [4:0]  memwb_rd = 5'd0;
  logic [4:0]  idex_rs1 = 5'd0;
  logic [4:0]  idex_rs2 = 5'd0;
  logic        cnt_clr = 1'b0;

  logic [1:0]  fa, fb, fa_n, fb_n;
  logic [31:0] cnt_ex, cnt_wb;
  logic [2:0]  cnt_ex_n, cnt_wb_n;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  longint m_ex = 0;
  longint m_wb = 0;

  forwarding_unit dut (
    .clk(clk), .rst(rst),
    .exmem_regwr(exmem_regwr), .exmem_rd(exmem_rd),
    .memwb_regwr(memwb_regwr), .memwb_rd(memwb_rd),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
    .forwardA(fa), .forwardB(fb),
    .cnt_clr(cnt_clr),
    .fwd_cnt_exmem(cnt_ex), .fwd_cnt_memwb(cnt_wb)
  );

  forwarding_unit #(.CNT_W(3)) dut_n (
    .clk(clk), .rst(rst),
    .exmem_regwr(exmem_regwr), .exmem_rd(exmem_rd),
    .memwb_regwr(memwb_regwr), .memwb_rd(memwb_rd),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
    .forwardA(fa_n), .forwardB(fb_n),
    .cnt_clr(cnt_clr),
    .fwd_cnt_exmem(cnt_ex_n), .fwd_cnt_memwb(cnt_wb_n)
  );

  always #10 clk = ~clk;

  // Reference: which stage (if any) supplies register rs; 0 = RF, 1 = MEM/WB, 2 = EX/MEM.
  function automatic int src_of(input logic [4:0] rs);
    if (exmem_regwr && exmem_rd != 5'd0 && exmem_rd == rs) return 2;
    if (memwb_regwr && memwb_rd != 5'd0 && memwb_rd == rs) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] enc(input int src);
    case (src)
      2:       return 2'b10;
      1:       return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model counters as unbounded totals; wrap is applied only when comparing.
  always @(posedge clk or posedge rst) begin
    if (rst || cnt_clr) begin
      m_ex = 0;
      m_wb = 0;
    end else begin
      m_ex = m_ex + ((src_of(idex_rs1) == 2) ? 1 : 0) + ((src_of(idex_rs2) == 2) ? 1 : 0);
      m_wb = m_wb + ((src_of(idex_rs1) == 1) ? 1 : 0) + ((src_of(idex_rs2) == 1) ? 1 : 0);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_fwdA", fa, enc(src_of(idex_rs1)));
      chk("cyc_fwdB", fb, enc(src_of(idex_rs2)));
      chk("cyc_fwdA_n", fa_n, enc(src_of(idex_rs1)));
      chk("cyc_fwdB_n", fb_n, enc(src_of(idex_rs2)));
      chk("cyc_cnt_ex", cnt_ex, m_ex % 64'h1_0000_0000);
      chk("cyc_cnt_wb", cnt_wb, m_wb % 64'h1_0000_0000);
      chk("cyc_cnt_ex_n", cnt_ex_n, m_ex % 8);
      chk("cyc_cnt_wb_n", cnt_wb_n, m_wb % 8);
    end
  end

  task automatic set_in(input logic ewr, input logic [4:0] erd, input logic wwr,
                        input logic [4:0] wrd, input logic [4:0] r1, input logic [4:0] r2);
    exmem_regwr = ewr; exmem_rd = erd;
    memwb_regwr = wwr; memwb_rd = wrd;
    idex_rs1 = r1; idex_rs2 = r2;
    #1;
  endtask

  // Advance n rising edges and park the driver just after the next falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk); #2;
    chk("rst_cnt_ex", cnt_ex, 0);
    chk("rst_cnt_wb", cnt_wb, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick(1);

    set_in(1'b1, 5'd0, 1'b0, 5'd1, 5'd0, 5'd1);
    chk("x0_fwdA", fa, 2'b00);
    chk("wr0_fwdB", fb, 2'b00);

    set_in(1'b1, 5'd1, 1'b0, 5'd2, 5'd1, 5'd0);
    chk("exmem_fwdA", fa, 2'b10);
    chk("exmem_fwdB", fb, 2'b00);

    set_in(1'b1, 5'd3, 1'b1, 5'd3, 5'd3, 5'd1);
    chk("prio_fwdA", fa, 2'b10);
    chk("prio_fwdB", fb, 2'b00);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk("clr_prio_ex", cnt_ex, 0);

    set_in(1'b0, 5'd5, 1'b1, 5'd5, 5'd5, 5'd5);
    chk("memwb_fwdA", fa, 2'b01);
    chk("memwb_fwdB", fb, 2'b01);
    tick(3);
    chk("memwb_cnt6", cnt_wb, 6);
    chk("memwb_cnt_ex0", cnt_ex, 0);

    set_in(1'b1, 5'd7, 1'b0, 5'd0, 5'd7, 5'd7);
    chk("both_ex_fwdA", fa, 2'b10);
    chk("both_ex_fwdB", fb, 2'b10);
    tick(2);
    chk("ex_cnt4", cnt_ex, 4);
    chk("ex_cnt_wb6", cnt_wb, 6);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk("clr_ex", cnt_ex, 0);
    chk("clr_wb", cnt_wb, 0);
    tick(2);
    chk("ex_cnt4b", cnt_ex, 4);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_ex", cnt_ex, 0);
    chk("async_rst_wb", cnt_wb, 0);
    chk("rst_fwdA", fa, 2'b10);
    chk("rst_fwdB", fb, 2'b10);
    tick(2);
    chk("rst_hold_ex", cnt_ex, 0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_ex", cnt_ex, 2);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;

    set_in(1'b1, 5'd31, 1'b1, 5'd30, 5'd30, 5'd31);
    chk("hi_fwdA", fa, 2'b01);
    chk("hi_fwdB", fb, 2'b10);
    tick(7);
    chk("pre_wrap_n", cnt_ex_n, 7);
    tick(1);
    chk("wrap0_ex_n", cnt_ex_n, 0);
    chk("wrap0_wb_n", cnt_wb_n, 0);
    chk("nowrap_ex", cnt_ex, 8);
    tick(1);
    chk("wrap1_ex_n", cnt_ex_n, 1);
    chk("wrap1_wb_n", cnt_wb_n, 1);

    for (int i = 0; i < 2000; i++) begin
      logic narrow;
      narrow = ($urandom_range(0, 3) != 0);
      exmem_regwr = 1'($urandom_range(0, 1));
      memwb_regwr = 1'($urandom_range(0, 1));
      exmem_rd = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      memwb_rd = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      idex_rs1 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      idex_rs2 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      cnt_clr = ($urandom_range(0, 31) == 0);
      rst = ($urandom_range(0, 127) == 0);
      tick(1);
    end
    rst = 1'b0;
    cnt_clr = 1'b0;
    tick(1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/forwarding_unit.md
Name: forwarding_unit

Overview:
- Pipeline data-forwarding (bypass) selector for the 5-stage RISC-V core.
- Compares the ID/EX source registers against the destination registers of the instructions in EX/MEM and MEM/WB.
- Produces 2-bit mux selects for the two ALU operand muxes in EX.
- Also keeps registered counters of forwarding events, used for performance monitoring.

Parameters:
- REG_AW, 5, register-address width (32 architectural registers).
- CNT_W, 32, width of each forwarding-event counter.

Ports:
- clk  in  1  core clock; used only by the counters.
- rst  in  1  asynchronous, active-high reset.
- exmem_regwr  in  1  EX/MEM instruction writes the register file.
- exmem_rd  in  REG_AW  EX/MEM destination register.
- memwb_regwr  in  1  MEM/WB instruction writes the register file.
- memwb_rd  in  REG_AW  MEM/WB destination register.
- idex_rs1  in  REG_AW  ID/EX source register 1.
- idex_rs2  in  REG_AW  ID/EX source register 2.
- forwardA  out  2  operand-A mux select.
- forwardB  out  2  operand-B mux select.
- cnt_clr  in  1  synchronous clear of both counters.
- fwd_cnt_exmem  out  CNT_W  count of operand forwards sourced from EX/MEM.
- fwd_cnt_memwb  out  CNT_W  count of operand forwards sourced from MEM/WB.

Behaviour:
- Select encoding (shared constants):
  - 2'b00 = register-file value (no forward).
  - 2'b10 = EX/MEM ALU result.
  - 2'b01 = MEM/WB write-back value.
  - 2'b11 is never driven.
- forwardA and forwardB are purely combinational, zero latency, and independent of clk/rst.
- Per operand X (rs1 → forwardA, rs2 → forwardB):
  - If exmem_regwr = 1, exmem_rd ≠ 0 and exmem_rd == idex_rsX, then select = 10.
  - Otherwise, if memwb_regwr = 1, memwb_rd ≠ 0 and memwb_rd == idex_rsX, then select = 01.
  - Otherwise select = 00.
- x0 rule: a destination of 0 never forwards, even when its regwr = 1.
- Priority: when EX/MEM and MEM/WB both match the same source, EX/MEM (the younger result) wins → 10.
- Both operands may forward in the same cycle, from the same or different stages.
- Both operands may match the same destination register.
- A regwr bit of 0 suppresses forwarding from that stage regardless of rd.
- Counters:
  - On each rising clk, fwd_cnt_exmem += (forwardA==10) + (forwardB==10), adding 0, 1 or 2.
  - On each rising clk, fwd_cnt_memwb += (forwardA==01) + (forwardB==01).
  - Counters wrap modulo 2^CNT_W.
  - cnt_clr = 1 at a clock edge loads 0; clear has priority over increment in that cycle.
  - rst asserted → both counters 0 immediately, with no clock needed, and held at 0 while rst is high.
  - Reset asserted mid-operation discards all counts.
  - Forward selects stay valid during reset, because they are combinational.

Decomposition:
- Shared package holds:
  - FWD_RF = 2'b00, FWD_EXMEM = 2'b10, FWD_MEMWB = 2'b01.
  - Register-address width (5).
- One sub-module, fwd_select: combinational single-operand comparator (rs, exmem_regwr/rd, memwb_regwr/rd → 2-bit select).
- fwd_select is instantiated twice, once for rs1 and once for rs2.
- Counters live in the top.

Test Plan:
- exmem_regwr=1, exmem_rd=0, memwb_regwr=0, memwb_rd=1, rs1=0, rs2=1 → forwardA=00 (x0 never forwarded), forwardB=00 (memwb_regwr low).
- exmem_regwr=1, exmem_rd=1, memwb_regwr=0, memwb_rd=2, rs1=1, rs2=0 → forwardA=10, forwardB=00.
- exmem_regwr=1, exmem_rd=3, memwb_regwr=1, memwb_rd=3, rs1=3, rs2=1 → forwardA=10 (EX/MEM priority), forwardB=00.
- exmem_regwr=0, exmem_rd=5, memwb_regwr=1, memwb_rd=5, rs1=5, rs2=5 → forwardA=01, forwardB=01. Clock 3 cycles → fwd_cnt_memwb=6, fwd_cnt_exmem=0.
- exmem_regwr=1, exmem_rd=7, rs1=7, rs2=7 → both 10, fwd_cnt_exmem +2 per clock:
  - Assert cnt_clr for one edge → 0.
  - Assert rst between edges → both counters 0 asynchronously.
  - Selects are unaffected by rst.
- exmem_rd=31, memwb_rd=30, both regwr=1, rs1=30, rs2=31 → forwardA=01, forwardB=10. Preload counters near 2^CNT_W−1 and clock → counters wrap to 0/1.
